clk_divider_multi: RTL and testbench

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

---
 rtl/clk_divider_multi.sv | 122 ++++++++++++
 tb/tb_clk_divider_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: N_CH independent 50%-duty clock dividers driven from one
// system clock. Each channel counts half-periods of programmable length H.
// New half-periods arrive through a valid/ready config port, are held as
// pending and take effect only at a period boundary (or immediately while the
// channel is disabled), so the output never produces a runt pulse.
module clk_divider_multi #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_HALF = 7142857,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  logic [CNT_W-1:0] cnt_q       [N_CH];
  logic [CNT_W-1:0] cnt_d       [N_CH];
  logic [CNT_W-1:0] half_q      [N_CH];
  logic [CNT_W-1:0] half_d      [N_CH];
  logic [CNT_W-1:0] pend_half_q [N_CH];
  logic [CNT_W-1:0] pend_half_d [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic             err_q, err_d;

  logic ch_in_range;
  logic ch_pend;
  logic accept;
  logic cfg_ok;

  // Config port decode: readiness of the addressed channel and transfer qualification.
  always_comb begin
    ch_in_range = (32'(cfg_ch) < N_CH);
    ch_pend     = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) ch_pend = pend_q[i];
    end
    cfg_ready = rst & (~ch_in_range | ~ch_pend);
    accept    = cfg_valid & cfg_ready;
    cfg_ok    = accept & ch_in_range & (cfg_half != '0);
  end

  // Per-channel next state: counting, toggling, pending-half loading and config capture.
  always_comb begin
    err_d  = accept & ~cfg_ok;
    pend_d = pend_q;
    out_d  = out_q;
    tick_d = tick_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i]       = cnt_q[i];
      half_d[i]      = half_q[i];
      pend_half_d[i] = pend_half_q[i];

      if (!en[i]) begin
        cnt_d[i]  = '0;
        out_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        if (pend_q[i]) begin
          half_d[i] = pend_half_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
        cnt_d[i]  = '0;
        out_d[i]  = ~out_q[i];
        tick_d[i] = ~out_q[i];
        // A falling toggle closes the period: the only safe point to swap H.
        if (out_q[i] && pend_q[i]) begin
          half_d[i] = pend_half_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        tick_d[i] = 1'b0;
      end

      // A transfer needs pend_q=0, so it can never collide with a load above.
      if (cfg_ok && (cfg_ch == CH_W'(i))) begin
        pend_d[i]      = 1'b1;
        pend_half_d[i] = cfg_half;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]       <= '0;
        half_q[i]      <= CNT_W'(DEF_HALF);
        pend_half_q[i] <= '0;
      end
      pend_q <= '0;
      out_q  <= '0;
      tick_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]       <= cnt_d[i];
        half_q[i]      <= half_d[i];
        pend_half_q[i] <= pend_half_d[i];
      end
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: a 4-channel instance checked every cycle
// against a period-position model, and a 3-channel instance exercised with a
// table of rejected configuration requests.
module tb_clk_divider_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned DH  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel DUT
  logic           rst;
  logic [3:0]     en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_half;
  logic           cfg_err;
  logic [3:0]     clk_out;
  logic [3:0]     tick;

  clk_divider_multi #(.N_CH(NCH), .CNT_W(CW), .DEF_HALF(DH)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick)
  );

  // 3-channel DUT
  logic           rst3;
  logic [2:0]     en3;
  logic           valid3;
  logic           ready3;
  logic [1:0]     ch3;
  logic [CW-1:0]  half3;
  logic           err3;
  logic [2:0]     out3;
  logic [2:0]     tick3;

  clk_divider_multi #(.N_CH(3), .CNT_W(CW), .DEF_HALF(DH)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .cfg_valid(valid3), .cfg_ready(ready3),
    .cfg_ch(ch3), .cfg_half(half3), .cfg_err(err3),
    .clk_out(out3), .tick(tick3)
  );

  int tests = 0;
  int fails = 0;

  // Model: k = enabled edges since the current period began (0..2H-1).
  // Output is high for k in [H, 2H); tick when k reaches H.
  int   k    [NCH];
  int   h    [NCH];
  int   ph   [NCH];
  bit   pend [NCH];
  logic [3:0] tick_m;
  logic       err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] e, input logic v,
                      input logic [1:0] c, input logic [CW-1:0] hf, output logic rdy);
    logic       exp_rdy;
    logic       acc;
    logic [3:0] eo;
    @(negedge clk);
    rst = r; en = e; cfg_valid = v; cfg_ch = c; cfg_half = hf;
    #1;
    exp_rdy = r && !pend[c];
    rdy = exp_rdy;
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < NCH; i++) begin
        k[i] = 0; h[i] = DH; pend[i] = 0;
      end
      tick_m = '0;
      err_m  = 1'b0;
    end else begin
      acc   = v && exp_rdy;
      err_m = acc && (hf == 0);
      for (int i = 0; i < NCH; i++) begin
        tick_m[i] = 1'b0;
        if (!e[i]) begin
          k[i] = 0;
          if (pend[i]) begin h[i] = ph[i]; pend[i] = 0; end
        end else begin
          k[i]++;
          if (k[i] == h[i]) tick_m[i] = 1'b1;
          if (k[i] == 2 * h[i]) begin
            k[i] = 0;
            if (pend[i]) begin h[i] = ph[i]; pend[i] = 0; end
          end
        end
      end
      if (acc && hf != 0) begin
        pend[c] = 1;
        ph[c]   = int'(hf);
      end
    end
    #1;
    for (int i = 0; i < NCH; i++) eo[i] = (k[i] >= h[i]);
    chk("clk_out", 32'(clk_out), 32'(eo));
    chk("tick",    32'(tick),    32'(tick_m));
    chk("cfg_err", 32'(cfg_err), 32'(err_m));
  endtask

  task automatic idle(input int n, input logic [3:0] e);
    logic d;
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 2'd0, '0, d);
  endtask

  typedef struct {
    logic [1:0]    ch;
    logic [CW-1:0] half;
    logic          exp_rdy;
    logic          exp_err;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic       d;
    logic       done;
    logic [3:0] ren;

    tbl[0] = '{2'd0, 8'd0, 1'b1, 1'b1};
    tbl[1] = '{2'd3, 8'd5, 1'b1, 1'b1};
    tbl[2] = '{2'd1, 8'd0, 1'b1, 1'b1};
    tbl[3] = '{2'd2, 8'd0, 1'b1, 1'b1};
    tbl[4] = '{2'd3, 8'd0, 1'b1, 1'b1};

    for (int i = 0; i < NCH; i++) begin k[i] = 0; h[i] = DH; ph[i] = 0; pend[i] = 0; end
    tick_m = '0; err_m = 1'b0;
    rst = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
    rst3 = 1'b0; en3 = '0; valid3 = 1'b0; ch3 = '0; half3 = '0;

    // ---- 3-channel instance: rejected requests leave every H untouched ----
    repeat (2) @(negedge clk);
    #1;
    chk("n3_ready_in_reset", 32'(ready3), 32'd0);
    @(posedge clk); #1;
    chk("n3_reset_out", 32'({out3, tick3, err3}), 32'd0);
    @(negedge clk); rst3 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      valid3 = 1'b1; ch3 = tbl[t].ch; half3 = tbl[t].half;
      #1;
      chk("n3_ready", 32'(ready3), 32'(tbl[t].exp_rdy));
      @(posedge clk); #1;
      chk("n3_err_pulse", 32'(err3), 32'(tbl[t].exp_err));
      @(negedge clk); valid3 = 1'b0;
      @(posedge clk); #1;
      chk("n3_err_clear", 32'(err3), 32'd0);
    end
    @(negedge clk); en3 = 3'b111;
    @(posedge clk); @(posedge clk); #1;
    chk("n3_out_edge2", 32'(out3), 32'd0);
    @(posedge clk); #1;
    chk("n3_out_edge3", 32'(out3), 32'h7);
    chk("n3_tick_edge3", 32'(tick3), 32'h7);
    @(posedge clk); #1;
    chk("n3_tick_edge4", 32'(tick3), 32'd0);

    // ---- 4-channel instance ----
    step(1'b0, 4'h0, 1'b0, 2'd0, '0, d);
    step(1'b0, 4'h0, 1'b1, 2'd1, 8'd2, d);

    // ch0 alone, H=3: rises on 3rd edge, period 6
    idle(14, 4'b0001);

    // ch1 mid-high gets H=1; switches to clk/2 at the period end
    step(1'b0, 4'h0, 1'b0, 2'd0, '0, d);
    idle(4, 4'b0010);
    step(1'b1, 4'b0010, 1'b1, 2'd1, 8'd1, d);
    idle(10, 4'b0010);

    // en[0] dropped in high phase, then re-enabled
    step(1'b0, 4'h0, 1'b0, 2'd0, '0, d);
    idle(4, 4'b0001);
    idle(2, 4'b0000);
    idle(8, 4'b0001);

    // second cfg to ch2 while pending: held valid until the period end frees it
    step(1'b0, 4'h0, 1'b0, 2'd0, '0, d);
    idle(1, 4'b0100);
    step(1'b1, 4'b0100, 1'b1, 2'd2, 8'd2, d);
    done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      step(1'b1, 4'b0100, 1'b1, 2'd2, 8'd4, d);
      done = d;
    end
    chk("ch2_held_transfer", 32'(done), 32'd1);
    idle(20, 4'b0100);

    // reset mid-operation with ch1 pending
    idle(3, 4'b1111);
    step(1'b1, 4'b1111, 1'b1, 2'd1, 8'd2, d);
    idle(1, 4'b1111);
    step(1'b0, 4'b1111, 1'b1, 2'd1, 8'd4, d);
    idle(12, 4'b1111);

    // randomized traffic
    ren = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) ren = 4'($urandom);
      step(($urandom_range(0, 199) != 0), ren, ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 5)), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
